// File: rtl/gray_updown_counter.sv
// Up/down counter with registered binary and Gray views that always agree.
// Supports synchronous load, wrap or saturate at the limits, and an overflow pulse.
module gray_updown_counter #(
  parameter int             W    = 4,
  parameter logic [W-1:0]   INIT = '0,
  parameter bit             SAT  = 1'b0
) (
  input  logic         clk,
  input  logic         areset,
  input  logic         ce,
  input  logic         dir,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt_bin,
  output logic [W-1:0] cnt_gray,
  output logic         ovf
);

  localparam logic [W-1:0] MAXV = '1;
  localparam logic [W-1:0] ONE  = W'(1);

  function automatic logic [W-1:0] to_gray(input logic [W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [W-1:0] bin, bin_nxt;
  logic [W-1:0] gray_q;
  logic         ovf_q, ovf_nxt;

  always_comb begin
    bin_nxt = bin;
    ovf_nxt = 1'b0;
    if (load) begin
      bin_nxt = load_val;
    end else if (ce && dir) begin
      if (bin == MAXV) begin
        ovf_nxt = 1'b1;
        if (!SAT) bin_nxt = '0;
      end else begin
        bin_nxt = bin + ONE;
      end
    end else if (ce) begin
      if (bin == '0) begin
        ovf_nxt = 1'b1;
        if (!SAT) bin_nxt = MAXV;
      end else begin
        bin_nxt = bin - ONE;
      end
    end
  end

  // Gray is registered from the next binary value so both views change on the same edge.
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      bin    <= INIT;
      gray_q <= to_gray(INIT);
      ovf_q  <= 1'b0;
    end else begin
      bin    <= bin_nxt;
      gray_q <= to_gray(bin_nxt);
      ovf_q  <= ovf_nxt;
    end
  end

  assign cnt_bin  = bin;
  assign cnt_gray = gray_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_gray_updown_counter.sv
// Bench for gray_updown_counter: directed W=4 vectors (wrap and saturate) plus a
// W=5 random run, all checked by a queue-based scoreboard decoupled from stimulus.
module tb_gray_updown_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // u0: W=4 INIT=0 wrap; u1: W=4 INIT=3 saturate
  logic       ar0 = 1'b0, ce0 = 1'b1, dir0 = 1'b1, load0 = 1'b0;
  logic [3:0] lv0 = '0, b0, g0;
  logic       o0;
  logic       ar1 = 1'b0, ce1 = 1'b0, dir1 = 1'b1, load1 = 1'b0;
  logic [3:0] lv1 = '0, b1, g1;
  logic       o1;
  // u2: W=5 wrap; u3: W=5 saturate
  logic       ar_r = 1'b0;
  logic       ce2 = 1'b0, dir2 = 1'b0, load2 = 1'b0;
  logic [4:0] lv2 = '0, b2, g2;
  logic       o2;
  logic       ce3 = 1'b0, dir3 = 1'b0, load3 = 1'b0;
  logic [4:0] lv3 = '0, b3, g3;
  logic       o3;

  gray_updown_counter #(.W(4), .INIT(4'd0), .SAT(1'b0)) u0 (
    .clk(clk), .areset(ar0), .ce(ce0), .dir(dir0), .load(load0), .load_val(lv0),
    .cnt_bin(b0), .cnt_gray(g0), .ovf(o0));
  gray_updown_counter #(.W(4), .INIT(4'd3), .SAT(1'b1)) u1 (
    .clk(clk), .areset(ar1), .ce(ce1), .dir(dir1), .load(load1), .load_val(lv1),
    .cnt_bin(b1), .cnt_gray(g1), .ovf(o1));
  gray_updown_counter #(.W(5), .INIT(5'd0), .SAT(1'b0)) u2 (
    .clk(clk), .areset(ar_r), .ce(ce2), .dir(dir2), .load(load2), .load_val(lv2),
    .cnt_bin(b2), .cnt_gray(g2), .ovf(o2));
  gray_updown_counter #(.W(5), .INIT(5'd0), .SAT(1'b1)) u3 (
    .clk(clk), .areset(ar_r), .ce(ce3), .dir(dir3), .load(load3), .load_val(lv3),
    .cnt_bin(b3), .cnt_gray(g3), .ovf(o3));

  typedef struct packed { logic [3:0] b; logic [3:0] g; logic o; } dexp_t;
  typedef struct packed { logic [4:0] b; logic o; logic ld; } rexp_t;

  dexp_t q0[$], q1[$];
  rexp_t q2[$], q3[$];

  int n_chk = 0, n_fail = 0;
  bit ddone = 1'b0, rdone = 1'b0;
  logic [4:0] pb[2] = '{5'd0, 5'd0};
  logic [4:0] pg[2] = '{5'd0, 5'd0};

  // Hand-written Gray sequence for 0..15
  logic [3:0] upg[16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                          4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, queue the expected post-edge outputs, then wait to the next negedge.
  task automatic dstep(input int d, input logic l, input logic c, input logic dr,
                       input logic [3:0] lv, input logic [3:0] eb, input logic [3:0] eg,
                       input logic eo);
    dexp_t e;
    e.b = eb; e.g = eg; e.o = eo;
    if (d == 0) begin
      load0 = l; ce0 = c; dir0 = dr; lv0 = lv; q0.push_back(e);
    end else begin
      load1 = l; ce1 = c; dir1 = dr; lv1 = lv; q1.push_back(e);
    end
    @(negedge clk);
  endtask

  function automatic rexp_t mstep(input bit sat, input logic l, input logic c, input logic d,
                                  input logic [4:0] lv, input logic [4:0] m);
    rexp_t r;
    r.b = m; r.o = 1'b0; r.ld = l;
    if (l) r.b = lv;
    else if (c && d) begin
      if (m == 5'd31) begin r.o = 1'b1; if (!sat) r.b = 5'd0; end
      else r.b = m + 5'd1;
    end else if (c) begin
      if (m == 5'd0) begin r.o = 1'b1; if (!sat) r.b = 5'd31; end
      else r.b = m - 5'd1;
    end
    return r;
  endfunction

  task automatic chk_r(input int i, input logic [4:0] b, input logic [4:0] g, input logic o,
                       input rexp_t e);
    chk($sformatf("rnd%0d_bin", i), 32'(b), 32'(e.b));
    chk($sformatf("rnd%0d_ovf", i), 32'(o), 32'(e.o));
    chk($sformatf("rnd%0d_gray", i), 32'(g), 32'(e.b ^ (e.b >> 1)));
    if (!e.ld && b != pb[i])
      chk($sformatf("rnd%0d_hamming", i), 32'($countones(g ^ pg[i])), 32'd1);
    pb[i] = b;
    pg[i] = g;
  endtask

  // Monitor: pops one expectation per DUT per edge, sampled 1 time unit after the edge.
  always @(posedge clk) begin
    dexp_t de;
    rexp_t re;
    #1;
    if (q0.size() > 0) begin
      de = q0.pop_front();
      chk("u0_bin", 32'(b0), 32'(de.b));
      chk("u0_gray", 32'(g0), 32'(de.g));
      chk("u0_ovf", 32'(o0), 32'(de.o));
    end
    if (q1.size() > 0) begin
      de = q1.pop_front();
      chk("u1_bin", 32'(b1), 32'(de.b));
      chk("u1_gray", 32'(g1), 32'(de.g));
      chk("u1_ovf", 32'(o1), 32'(de.o));
    end
    if (q2.size() > 0) begin re = q2.pop_front(); chk_r(0, b2, g2, o2, re); end
    if (q3.size() > 0) begin re = q3.pop_front(); chk_r(1, b3, g3, o3, re); end
  end

  // Directed vectors
  initial begin
    @(negedge clk);
    // reset held 10 cycles with ce/dir up, then full up sweep with wrap
    for (int k = 0; k < 10; k++) dstep(0, 0, 1, 1, 4'd0, 4'd0, 4'b0000, 0);
    ar0 = 1'b1;
    for (int k = 1; k < 16; k++) dstep(0, 0, 1, 1, 4'd0, 4'(k), upg[k], 0);
    dstep(0, 0, 1, 1, 4'd0, 4'd0, 4'b0000, 1);
    // down wrap
    dstep(0, 0, 1, 0, 4'd0, 4'd15, 4'b1000, 1);
    dstep(0, 0, 1, 0, 4'd0, 4'd14, 4'b1001, 0);
    // load priority, including load at the upper limit
    dstep(0, 1, 1, 1, 4'd5, 4'd5, 4'b0111, 0);
    dstep(0, 0, 1, 1, 4'd0, 4'd6, 4'b0101, 0);
    dstep(0, 1, 1, 1, 4'd15, 4'd15, 4'b1000, 0);
    dstep(0, 1, 1, 1, 4'd15, 4'd15, 4'b1000, 0);
    dstep(0, 0, 1, 1, 4'd0, 4'd0, 4'b0000, 1);
    dstep(0, 1, 1, 0, 4'd9, 4'd9, 4'b1101, 0);
    dstep(0, 0, 1, 1, 4'd0, 4'd10, 4'b1111, 0);
    dstep(0, 0, 1, 0, 4'd0, 4'd9, 4'b1101, 0);
    dstep(0, 0, 0, 1, 4'd0, 4'd9, 4'b1101, 0);
    ce0 = 1'b0;

    // saturating instance, INIT=3
    for (int k = 0; k < 3; k++) dstep(1, 0, 0, 1, 4'd0, 4'd3, 4'b0010, 0);
    ar1 = 1'b1;
    for (int k = 0; k < 5; k++) dstep(1, 0, 0, 1, 4'd0, 4'd3, 4'b0010, 0);
    for (int k = 4; k < 16; k++) dstep(1, 0, 1, 1, 4'd0, 4'(k), upg[k], 0);
    for (int k = 0; k < 3; k++) dstep(1, 0, 1, 1, 4'd0, 4'd15, 4'b1000, 1);
    for (int k = 14; k >= 0; k--) dstep(1, 0, 1, 0, 4'd0, 4'(k), upg[k], 0);
    for (int k = 0; k < 3; k++) dstep(1, 0, 1, 0, 4'd0, 4'd0, 4'b0000, 1);
    dstep(1, 0, 0, 0, 4'd0, 4'd0, 4'b0000, 0);
    dstep(1, 0, 1, 1, 4'd0, 4'd1, 4'b0001, 0);
    dstep(1, 0, 1, 1, 4'd0, 4'd2, 4'b0011, 0);
    // async reset between edges, then held across an edge with ce high
    #2 ar1 = 1'b0;
    #1;
    chk("u1_async_bin", 32'(b1), 32'd3);
    chk("u1_async_gray", 32'(g1), 32'b0010);
    chk("u1_async_ovf", 32'(o1), 32'd0);
    @(posedge clk);
    #1;
    chk("u1_rsthold_bin", 32'(b1), 32'd3);
    ddone = 1'b1;
  end

  // Random run on both W=5 instances
  initial begin
    logic [4:0] m2, m3;
    rexp_t e;
    m2 = '0;
    m3 = '0;
    repeat (3) @(negedge clk);
    ar_r = 1'b1;
    for (int k = 0; k < 10000; k++) begin
      load2 = ($urandom_range(0, 15) == 0);
      ce2   = ($urandom_range(0, 3) != 0);
      dir2  = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: lv2 = 5'd0;
        1: lv2 = 5'd31;
        default: lv2 = 5'($urandom_range(0, 31));
      endcase
      e = mstep(1'b0, load2, ce2, dir2, lv2, m2);
      m2 = e.b;
      q2.push_back(e);
      load3 = ($urandom_range(0, 15) == 0);
      ce3   = ($urandom_range(0, 3) != 0);
      dir3  = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: lv3 = 5'd0;
        1: lv3 = 5'd31;
        default: lv3 = 5'($urandom_range(0, 31));
      endcase
      e = mstep(1'b1, load3, ce3, dir3, lv3, m3);
      m3 = e.b;
      q3.push_back(e);
      @(negedge clk);
    end
    ce2 = 1'b0; load2 = 1'b0; ce3 = 1'b0; load3 = 1'b0;
    @(negedge clk);
    rdone = 1'b1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout checks=%0d", n_chk);
    $fatal(1, "timeout");
  end

  initial begin
    wait (ddone && rdone);
    @(negedge clk);
    chk("queues_drained", 32'(q0.size() + q1.size() + q2.size() + q3.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
